// File: rtl/noc_rr_fifo_arbiter.sv
// Round-robin read scheduler for a router output link.
// Picks one enabled, non-empty input FIFO, pulses its read enable, captures
// the FIFO's registered output one cycle later and offers the packet
// downstream on a valid/ready interface. A new decision is made only after
// the previous packet has been handed off.
module noc_rr_fifo_arbiter #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 8,
    parameter int SRC_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN-1:0]        port_en,
    input  logic [NUM_IN-1:0]        in_empty,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    output logic [NUM_IN-1:0]        in_rd_en,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SRC_W-1:0]         out_src,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_SEND = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [SRC_W-1:0]  prio_ptr;
    logic [NUM_IN-1:0] req;
    logic              grant_found;
    logic [SRC_W-1:0]  grant_idx;
    logic [SRC_W-1:0]  cand;

    assign req = port_en & ~in_empty;

    // Winner search: first requesting input at or above prio_ptr, wrapping.
    // NUM_IN is a power of two, so the SRC_W-bit add wraps modulo NUM_IN.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // otherwise a path that skips the assignment would infer a latch.
        grant_found = 1'b0;
        grant_idx   = prio_ptr;
        cand        = prio_ptr;
        for (int k = 0; k < NUM_IN; k++) begin
            cand = prio_ptr + SRC_W'(k);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next-state logic: IDLE waits for a request, READ and WAIT last one
    // cycle each, SEND holds until the downstream handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_found) state_nxt = ST_READ;
            ST_READ: state_nxt = ST_WAIT;
            ST_WAIT: state_nxt = ST_SEND;
            ST_SEND: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, priority pointer and output packet registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            prio_ptr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values, independent of statement order.
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (grant_found) out_src <= grant_idx;
                end
                ST_WAIT: begin
                    out_data  <= in_data[out_src*DATA_W +: DATA_W];
                    out_valid <= 1'b1;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        prio_ptr  <= out_src + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read-enable pulse is decoded from state so it lasts exactly the READ cycle.
    assign in_rd_en = (state == ST_READ) ? (NUM_IN'(1) << out_src) : '0;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_noc_rr_fifo_arbiter.sv
// Self-checking bench for noc_rr_fifo_arbiter.
// The environment emulates the input FIFOs as byte queues with a registered
// data output. A transaction-level model predicts, cycle by cycle, which
// input is granted, when its read pulse appears and when the packet is
// offered downstream; one compare step checks the DUT against it.
module tb_noc_rr_fifo_arbiter;

    localparam int NUM_IN = 4;
    localparam int DATA_W = 8;
    localparam int SRC_W  = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_IN-1:0]        port_en;
    logic [NUM_IN-1:0]        in_empty;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_rd_en;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [SRC_W-1:0]         out_src;
    logic                     out_ready;
    logic                     busy;

    noc_rr_fifo_arbiter #(
        .NUM_IN (NUM_IN),
        .DATA_W (DATA_W),
        .SRC_W  (SRC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .port_en   (port_en),
        .in_empty  (in_empty),
        .in_data   (in_data),
        .in_rd_en  (in_rd_en),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // FIFO emulation
    logic [DATA_W-1:0] fifo_q [NUM_IN][$];
    logic [DATA_W-1:0] fifo_dout [NUM_IN];
    logic [NUM_IN-1:0] rd_sample;

    // Transaction-level model: m_age counts cycles since the grant decision
    // (1 = read pulse cycle, 2 = data cycle, >=3 = offering downstream).
    bit                m_busy;
    int                m_age;
    int                m_src;
    logic [DATA_W-1:0] m_data;
    int                m_ptr;

    // Observed events
    int                xfer_src[$];
    logic [DATA_W-1:0] xfer_data[$];
    int                rd_cyc[$];
    logic [NUM_IN-1:0] rd_val[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, act, exp);
        end
    endtask

    function automatic void fifo_refresh();
        for (int i = 0; i < NUM_IN; i++) begin
            in_empty[i]                 = (fifo_q[i].size() == 0);
            in_data[i*DATA_W +: DATA_W] = fifo_dout[i];
        end
    endfunction

    function automatic void fifo_flush();
        for (int i = 0; i < NUM_IN; i++) begin
            fifo_q[i].delete();
            fifo_dout[i] = '0;
        end
        fifo_refresh();
    endfunction

    function automatic void push(input int idx, input logic [DATA_W-1:0] val);
        fifo_q[idx].push_back(val);
        fifo_refresh();
    endfunction

    function automatic void clear_logs();
        xfer_src.delete();
        xfer_data.delete();
        rd_cyc.delete();
        rd_val.delete();
    endfunction

    function automatic void model_reset();
        m_busy = 1'b0;
        m_age  = 0;
        m_src  = 0;
        m_data = '0;
        m_ptr  = 0;
    endfunction

    // One clock of the model, using the inputs as they were before the edge.
    function automatic void model_step();
        if (!m_busy) begin
            for (int k = 0; k < NUM_IN; k++) begin
                int i;
                i = (m_ptr + k) % NUM_IN;
                if (!m_busy && port_en[i] && fifo_q[i].size() != 0) begin
                    m_busy = 1'b1;
                    m_age  = 1;
                    m_src  = i;
                    m_data = fifo_q[i][0];
                end
            end
        end else if (m_age >= 3) begin
            if (out_ready) begin
                m_busy = 1'b0;
                m_ptr  = (m_src + 1) % NUM_IN;
            end
        end else begin
            m_age++;
        end
    endfunction

    // Edge process: advance the model, then let the FIFOs react to the read
    // pulse that was present during the cycle that just ended.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (rst) begin
                model_reset();
            end else begin
                model_step();
                for (int i = 0; i < NUM_IN; i++) begin
                    if (rd_sample[i]) begin
                        if (fifo_q[i].size() != 0) fifo_dout[i] = fifo_q[i].pop_front();
                        else                       fifo_dout[i] = 8'hEE;
                    end
                end
            end
            fifo_refresh();
        end
    end

    task automatic check_outputs();
        logic [NUM_IN-1:0] exp_rd;
        exp_rd = (m_busy && m_age == 1) ? (4'b0001 << m_src) : 4'b0000;
        check("in_rd_en", in_rd_en, exp_rd);
        check("busy", busy, m_busy);
        check("out_valid", out_valid, m_busy && m_age >= 3);
        check("prio_ptr", dut.prio_ptr, m_ptr);
        if (m_busy) check("out_src", out_src, m_src);
        if (m_busy && m_age >= 3) check("out_data", out_data, m_data);
    endtask

    task automatic check_reset_values();
        check("rst in_rd_en", in_rd_en, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst out_src", out_src, 0);
        check("rst busy", busy, 0);
        check("rst prio_ptr", dut.prio_ptr, 0);
    endtask

    // Advance to the next falling edge and compare against the model.
    task automatic step();
        if (!rst && out_valid && out_ready) begin
            xfer_src.push_back(out_src);
            xfer_data.push_back(out_data);
        end
        @(negedge clk);
        check_outputs();
        rd_sample = in_rd_en;
        if (in_rd_en != 0) begin
            rd_cyc.push_back(cycle);
            rd_val.push_back(in_rd_en);
        end
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without an edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        rd_sample = '0;
        fifo_flush();
        check_reset_values();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int exp_seq[8];
        int v_cyc;
        logic [DATA_W-1:0] held_data;

        port_en   = 4'hF;
        out_ready = 1'b1;
        rd_sample = '0;
        model_reset();
        fifo_flush();
        #1;
        check_reset_values();
        @(negedge clk);
        do_reset();

        // Idle with all FIFOs empty
        for (int n = 0; n < 20; n++) begin
            step();
            check("idle rd_en", in_rd_en, 0);
            check("idle valid", out_valid, 0);
            check("idle busy", busy, 0);
        end
        check("idle model ptr", m_ptr, 0);

        // Single packet from FIFO2
        do_reset();
        clear_logs();
        push(2, 8'hA5);
        v_cyc = -1;
        for (int n = 0; n < 8; n++) begin
            step();
            if (out_valid && v_cyc < 0) v_cyc = cycle;
        end
        check("single rd count", rd_val.size(), 1);
        if (rd_val.size() > 0) begin
            check("single rd value", rd_val[0], 4'b0100);
            check("single valid delay", v_cyc - rd_cyc[0], 2);
        end
        check("single xfer count", xfer_src.size(), 1);
        if (xfer_src.size() > 0) begin
            check("single xfer src", xfer_src[0], 2);
            check("single xfer data", xfer_data[0], 8'hA5);
        end
        check("single model ptr", m_ptr, 3);
        check("single dut ptr", dut.prio_ptr, 3);

        // Full rotation with all inputs eligible
        do_reset();
        clear_logs();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_IN; i++) push(i, 8'(i*16 + r));
        for (int n = 0; n < 40; n++) step();
        exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
        check("rot xfer count", xfer_src.size(), 8);
        for (int j = 0; j < 8 && j < xfer_src.size(); j++) begin
            check("rot src", xfer_src[j], exp_seq[j]);
            check("rot data", xfer_data[j], 8'(exp_seq[j]*16 + j/4));
        end
        check("rot rd count", rd_cyc.size(), 8);
        for (int j = 1; j < rd_cyc.size(); j++)
            check("rot rd spacing", rd_cyc[j] - rd_cyc[j-1], 4);

        // Back-pressure on FIFO1
        do_reset();
        clear_logs();
        push(1, 8'h3C);
        push(1, 8'h3D);
        out_ready = 1'b0;
        for (int n = 0; n < 10 && !out_valid; n++) step();
        check("bp valid reached", out_valid, 1);
        held_data = out_data;
        check("bp first data", held_data, 8'h3C);
        for (int n = 0; n < 10; n++) begin
            step();
            check("bp hold valid", out_valid, 1);
            check("bp hold data", out_data, 8'h3C);
            check("bp hold src", out_src, 1);
        end
        check("bp rd count", rd_val.size(), 1);
        out_ready = 1'b1;
        step();
        check("bp xfer count", xfer_src.size(), 1);
        check("bp valid dropped", out_valid, 0);
        for (int n = 0; n < 8; n++) step();

        // Masked inputs: only 1 and 3 enabled
        do_reset();
        clear_logs();
        port_en = 4'b1010;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_IN; i++) push(i, 8'(8'h50 + i*4 + r));
        for (int n = 0; n < 40; n++) step();
        exp_seq = '{1, 3, 1, 3, 0, 0, 0, 0};
        check("mask xfer count", xfer_src.size(), 4);
        for (int j = 0; j < 4 && j < xfer_src.size(); j++)
            check("mask src", xfer_src[j], exp_seq[j]);
        port_en = 4'hF;

        // Reset while a packet is in the data cycle
        do_reset();
        clear_logs();
        push(3, 8'h77);
        for (int n = 0; n < 10 && !(m_busy && m_age == 2); n++) step();
        check("abort in wait", busy, 1);
        do_reset();
        check("abort no xfer", xfer_src.size(), 0);
        for (int i = 0; i < NUM_IN; i++) push(i, 8'(8'h90 + i));
        for (int n = 0; n < 20; n++) step();
        check("abort restart count", xfer_src.size() >= 1, 1);
        if (xfer_src.size() > 0) check("abort restart src", xfer_src[0], 0);

        // Randomized traffic, enables and back-pressure
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            if ($urandom_range(0, 2) == 0) begin
                int idx;
                idx = int'($urandom_range(0, NUM_IN-1));
                if (fifo_q[idx].size() < 8) push(idx, 8'($urandom));
            end
            if ($urandom_range(0, 15) == 0)
                port_en = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
